// File: rtl/tia_hmove_controller_pkg.sv
// Shared constants, state encoding and helpers for the HMOVE controller.
package tia_hmove_controller_pkg;

   // Object indices; also the bit positions inside mec_bar.
   localparam int OBJ_P0  = 0;
   localparam int OBJ_P1  = 1;
   localparam int OBJ_M0  = 2;
   localparam int OBJ_M1  = 3;
   localparam int OBJ_BL  = 4;
   localparam int NUM_OBJ = 5;

   // Motion register addresses; 6 and 7 are ignored.
   localparam logic [2:0] ADDR_HMP0  = 3'd0;
   localparam logic [2:0] ADDR_HMP1  = 3'd1;
   localparam logic [2:0] ADDR_HMM0  = 3'd2;
   localparam logic [2:0] ADDR_HMM1  = 3'd3;
   localparam logic [2:0] ADDR_HMBL  = 3'd4;
   localparam logic [2:0] ADDR_HMCLR = 3'd5;

   // One HMOVE sequence is always sixteen motion steps.
   localparam int NUM_STEPS = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } hmove_state_e;

   // Debug view of the sequencer for checkers and waveforms.
   typedef struct packed {
      hmove_state_e state;
      logic [3:0]   step;
   } hmove_dbg_t;

   // Signed motion value -8..+7 maps to 0..15 extra clocks by flipping the sign bit.
   function automatic logic [3:0] motion_to_count(input logic [3:0] value);
      return value ^ 4'b1000;
   endfunction

endpackage

// File: rtl/tia_hmove_controller_motion_register.sv
// One object's motion register, sequence snapshot and registered extra-clock enable.
module tia_hmove_controller_motion_register
   import tia_hmove_controller_pkg::*;
(
   input  logic       clkp,
   input  logic       reset,
   input  logic       wr_sel,
   input  logic       clr,
   input  logic [3:0] wr_data,
   input  logic       snap,
   input  logic       pulse_next,
   input  logic [3:0] pulse_step,
   output logic       mec_bar
);

   logic [3:0] value;
   logic [3:0] value_next;
   logic [3:0] n_snap;
   logic [3:0] n_cmp;

   // Next register value; the snapshot sees this so a same-cycle write is written through.
   always_comb begin
      value_next = value;
      if (clr) begin
         value_next = 4'd0;
      end else if (wr_sel) begin
         value_next = wr_data;
      end
      n_cmp = snap ? motion_to_count(value_next) : n_snap;
   end

   // Motion register: accepts writes and HMCLR in any sequencer state.
   always_ff @(posedge clkp or posedge reset) begin
      if (reset) begin
         value <= 4'd0;
      end else begin
         value <= value_next;
      end
   end

   // Snapshot on strobe, then pulse low for one cycle at each step start while step < n.
   always_ff @(posedge clkp or posedge reset) begin
      if (reset) begin
         n_snap  <= motion_to_count(4'd0);
         mec_bar <= 1'b1;
      end else begin
         if (snap) begin
            n_snap <= motion_to_count(value_next);
         end
         mec_bar <= !(pulse_next && (pulse_step < n_cmp));
      end
   end

endmodule

// File: rtl/tia_hmove_controller.sv
// HMOVE sequencer: step divider, step counter, blank extension and five motion registers.
//
// Interface protocol: wr_en/wr_addr/wr_data form a single-cycle write with no
// back-pressure; it is always accepted and lands on the next clkp edge.
// hmove_strobe is a single-cycle request, always accepted; a strobe while busy
// restarts the sequence. All outputs are registered.
module tia_hmove_controller
   import tia_hmove_controller_pkg::*;
#(
   parameter int STEP_CYCLES  = 4,
   parameter int BLANK_CYCLES = 8
) (
   input  logic       clkp,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [3:0] wr_data,
   input  logic       hmove_strobe,
   output logic [4:0] mec_bar,
   output logic       hmove_blank,
   output logic       busy,
   output hmove_dbg_t dbg
);

   localparam int DIV_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int BLK_W = $clog2(BLANK_CYCLES + 1);

   hmove_state_e       state;
   logic [DIV_W-1:0]   divider;
   logic [3:0]         step;
   logic [BLK_W-1:0]   blank_cnt;
   logic               step_end;
   logic               last_step;
   logic               pulse_next;
   logic [3:0]         pulse_step;
   logic               clr;

   // Decode the end of a step and which step (if any) starts on the next edge.
   always_comb begin
      step_end   = (state == ST_RUN) && (divider == DIV_W'(STEP_CYCLES - 1));
      last_step  = (step == 4'(NUM_STEPS - 1));
      pulse_next = hmove_strobe || (step_end && !last_step);
      pulse_step = hmove_strobe ? 4'd0 : step + 4'd1;
      clr        = wr_en && (wr_addr == ADDR_HMCLR);
   end

   // Sequencer FSM with divider, step counter and registered busy.
   always_ff @(posedge clkp or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         divider <= '0;
         step    <= 4'd0;
         busy    <= 1'b0;
      end else if (hmove_strobe) begin
         state   <= ST_RUN;
         divider <= '0;
         step    <= 4'd0;
         busy    <= 1'b1;
      end else if (state == ST_RUN) begin
         if (step_end) begin
            divider <= '0;
            if (last_step) begin
               state <= ST_IDLE;
               step  <= 4'd0;
               busy  <= 1'b0;
            end else begin
               step <= step + 4'd1;
            end
         end else begin
            divider <= divider + DIV_W'(1);
         end
      end
   end

   // Blank extension: high for BLANK_CYCLES cycles after each strobe, restarted by a new strobe.
   always_ff @(posedge clkp or posedge reset) begin
      if (reset) begin
         blank_cnt   <= '0;
         hmove_blank <= 1'b0;
      end else if (hmove_strobe) begin
         blank_cnt   <= BLK_W'(BLANK_CYCLES - 1);
         hmove_blank <= 1'b1;
      end else if (blank_cnt != '0) begin
         blank_cnt <= blank_cnt - BLK_W'(1);
      end else begin
         hmove_blank <= 1'b0;
      end
   end

   assign dbg.state = state;
   assign dbg.step  = step;

   for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
      tia_hmove_controller_motion_register u_reg (
         .clkp       (clkp),
         .reset      (reset),
         .wr_sel     (wr_en && (wr_addr == 3'(i))),
         .clr        (clr),
         .wr_data    (wr_data),
         .snap       (hmove_strobe),
         .pulse_next (pulse_next),
         .pulse_step (pulse_step),
         .mec_bar    (mec_bar[i])
      );
   end

endmodule
